// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, a one-cycle error pulse and sticky
// overflow/underflow status. RD_PRIORITY selects legacy read-priority
// (simultaneous requests perform the read only) or true concurrent read+write.
module sync_fifo_param #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int AF_LEVEL    = 6,
    parameter int AE_LEVEL    = 2,
    parameter int RD_PRIORITY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wen,
    input  logic                       ren,
    input  logic [DATA_W-1:0]          din,
    input  logic                       clr_status,
    output logic [DATA_W-1:0]          dout,
    output logic                       error,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [31:0]      AF_U     = 32'(AF_LEVEL);
    localparam logic [31:0]      AE_U     = 32'(AE_LEVEL);
    localparam logic             LEGACY   = (RD_PRIORITY != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              wr_req;
    logic              rd_ok;
    logic              wr_ok;
    logic              rd_bad;
    logic              wr_bad;
    logic [CNT_W-1:0]  count_next;

    // Resolve this edge's requests into legal/illegal operations and next count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_req     = 1'b0;
        rd_ok      = 1'b0;
        wr_ok      = 1'b0;
        rd_bad     = 1'b0;
        wr_bad     = 1'b0;
        count_next = count;

        // In legacy mode a simultaneous write is silently dropped, not an error.
        wr_req = wen && !(LEGACY && ren);
        rd_ok  = ren && (count != '0);
        rd_bad = ren && (count == '0);
        // A full FIFO still accepts a write when a legal read frees the slot on the same edge.
        wr_ok  = wr_req && ((count != DEPTH_C) || rd_ok);
        wr_bad = wr_req && !wr_ok;

        if (wr_ok && !rd_ok) begin
            count_next = count + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage array: written on legal writes only.
    // NOTE: the data array has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, registered read data, count, flags and status with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            dout         <= '0;
            count        <= '0;
            error        <= 1'b0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_U == 32'd0);
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_next;
            error        <= rd_bad || wr_bad;
            // A new illegal event takes precedence over a coincident clear.
            ovf          <= wr_bad || (ovf && !clr_status);
            udf          <= rd_bad || (udf && !clr_status);
            // Flags follow the next count so they always agree with count.
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (32'(count_next) >= AF_U);
            almost_empty <= (32'(count_next) <= AE_U);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: drives both the legacy (RD_PRIORITY=1) and the
// concurrent (RD_PRIORITY=0) variants with the same stimulus, predicts each
// from a queue-based reference model and compares in a separate monitor.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    typedef logic [DW-1:0] byte_q_t [$];

    typedef struct packed {
        logic [DW-1:0] dout;
        logic          error;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic [3:0]    count;
        logic          ovf;
        logic          udf;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [DW-1:0] din = '0;
    logic          clr_status = 1'b0;

    logic [DW-1:0] dout1, dout0;
    logic          error1, error0, full1, full0, empty1, empty0;
    logic          af1, af0, ae1, ae0, ovf1, ovf0, udf1, udf0;
    logic [3:0]    count1, count0;

    int total = 0;
    int bad   = 0;

    byte_q_t mq1, mq0;
    obs_t    ms1, ms0;
    obs_t    exp_q1 [$];
    obs_t    exp_q0 [$];

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .RD_PRIORITY(1)) dut_legacy (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .din(din), .clr_status(clr_status),
        .dout(dout1), .error(error1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1), .ovf(ovf1), .udf(udf1)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .RD_PRIORITY(0)) dut_conc (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .din(din), .clr_status(clr_status),
        .dout(dout0), .error(error0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0), .ovf(ovf0), .udf(udf0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue; rules are applied straight from the behaviour description.
    task automatic model_step(input bit prio, input bit w, input bit r, input logic [DW-1:0] d,
                              input bit clr, input bit rst, inout byte_q_t q, inout obs_t s);
        bit do_w, do_r, bad_w, bad_r;
        int n;
        if (rst) begin
            q.delete();
            s     = '0;
        end else begin
            do_w  = w && !(prio && r);
            bad_r = r && (q.size() == 0);
            do_r  = r && !bad_r;
            bad_w = do_w && (q.size() == DEPTH) && !do_r;
            do_w  = do_w && !bad_w;
            if (do_r) s.dout = q.pop_front();
            if (do_w) q.push_back(d);
            s.error = bad_r || bad_w;
            s.ovf   = bad_w || (s.ovf && !clr);
            s.udf   = bad_r || (s.udf && !clr);
        end
        n       = q.size();
        s.count = 4'(n);
        s.full  = (n == DEPTH);
        s.empty = (n == 0);
        s.af    = (n >= AF);
        s.ae    = (n <= AE);
    endtask

    task automatic cycle(input bit rst, input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
        @(negedge clk);
        rst_n      = !rst;
        wen        = w;
        ren        = r;
        din        = d;
        clr_status = clr;
        model_step(1'b1, w, r, d, clr, rst, mq1, ms1);
        model_step(1'b0, w, r, d, clr, rst, mq0, ms0);
        exp_q1.push_back(ms1);
        exp_q0.push_back(ms0);
    endtask

    task automatic idle_all();
        @(negedge clk);
        wen = 1'b0; ren = 1'b0; clr_status = 1'b0;
    endtask

    // Wait until just after the edge that consumed the last issued cycle.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic compare(input string tag, input obs_t a, input obs_t e);
        check({tag, ".dout"},   32'(a.dout),  32'(e.dout));
        check({tag, ".error"},  32'(a.error), 32'(e.error));
        check({tag, ".full"},   32'(a.full),  32'(e.full));
        check({tag, ".empty"},  32'(a.empty), 32'(e.empty));
        check({tag, ".afull"},  32'(a.af),    32'(e.af));
        check({tag, ".aempty"}, 32'(a.ae),    32'(e.ae));
        check({tag, ".count"},  32'(a.count), 32'(e.count));
        check({tag, ".ovf"},    32'(a.ovf),   32'(e.ovf));
        check({tag, ".udf"},    32'(a.udf),   32'(e.udf));
    endtask

    // Monitor: after every active edge, pop the predicted state of both variants and compare.
    always @(posedge clk) begin
        obs_t a1, a0;
        #1;
        if (exp_q1.size() != 0 && exp_q0.size() != 0) begin
            a1 = '{dout1, error1, full1, empty1, af1, ae1, count1, ovf1, udf1};
            a0 = '{dout0, error0, full0, empty0, af0, ae0, count0, ovf0, udf0};
            compare("legacy", a1, exp_q1.pop_front());
            compare("conc",   a0, exp_q0.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        ms1 = '0;
        ms0 = '0;

        // Reset held for two edges with requests active.
        cycle(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
        settle();
        check("rst.dout",  32'(dout1), 32'h0);
        check("rst.empty", 32'(empty0), 32'h1);

        // Fill 1..8, overflow with 9, drain, then underflow and clear.
        for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
        settle();
        check("fill.count", 32'(count1), 32'd8);
        check("fill.full",  32'(full0),  32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'd9, 1'b0);
        settle();
        check("ovf.error", 32'(error1), 32'd1);
        check("ovf.flag",  32'(ovf0),   32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        settle();
        check("drain.dout", 32'(dout0), 32'd8);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Simultaneous requests with one entry stored.
        cycle(1'b0, 1'b1, 1'b0, 8'd87, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'd85, 1'b0);
        settle();
        check("legacy.dual.dout",  32'(dout1),  32'd87);
        check("legacy.dual.count", 32'(count1), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);

        // Concurrent access at full, then at empty.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 10; i <= 17; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'd99, 1'b0);
        settle();
        check("conc.full.dout",  32'(dout0),  32'd10);
        check("conc.full.count", 32'(count0), 32'd8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'd5, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        settle();
        check("conc.empty.dout", 32'(dout0), 32'd5);

        // Pointer wrap: prefill, interleave writes and reads, then drain.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'(40 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cycle(1'b0, 1'b1, 1'b0, 8'(60 + i), 1'b0);
            else            cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Randomised traffic with occasional clear and reset.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 45,
                  8'($urandom),
                  $urandom_range(0, 99) < 6);
        end

        idle_all();
        repeat (3) @(negedge clk);
        check("scoreboard.drained", 32'(exp_q1.size() + exp_q0.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the successor to the team's fixed 8x8 FIFO. It adds configurable data width and depth, status flags, occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow status. A mode parameter selects either the legacy read-priority handling of simultaneous requests or true concurrent read+write. It sits between producer/consumer blocks in lab datapaths as a drop-in buffer.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
RD_PRIORITY, 1, 1 = legacy mode (wen&&ren performs read only); 0 = concurrent read+write

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  synchronous active-low reset
wen  input  1  write request
ren  input  1  read request
din  input  DATA_W  write data
clr_status  input  1  clears sticky ovf/udf
dout  output  DATA_W  registered read data
error  output  1  one-cycle illegal-operation pulse
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy
ovf  output  1  sticky: write attempted while full
udf  output  1  sticky: read attempted while empty

Behaviour:
- One clock; reset is synchronous and active-low: on a rising clk edge with rst_n=0, all state clears regardless of other inputs.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, dout=0, error=0, ovf=0, udf=0, full=0, empty=1, almost_full=(AF_LEVEL==0), almost_empty=1. Memory contents are not reset.
- All outputs are registered or decoded from registered count. There is no combinational path from input to output.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally. count is held separately and ranges 0..DEPTH.
- Valid write (edge k): mem[wr_ptr]<=din; wr_ptr+1.
- Valid read (edge k): dout<=mem[rd_ptr]; rd_ptr+1. Read latency is one edge: data is visible after edge k. dout holds its last value on any cycle with no valid read, including an illegal read.
- Legal-op resolution per edge, with R = ren and W = wen after mode resolution:
  - RD_PRIORITY=1 with ren&&wen: W is forced to 0. The write is silently dropped and is not an error.
  - Read only: legal if count>0, otherwise illegal (underflow).
  - Write only: legal if count<DEPTH, otherwise illegal (overflow).
  - RD_PRIORITY=0, both asserted, 0<count<DEPTH: both performed; count unchanged.
  - RD_PRIORITY=0, both asserted, count==DEPTH: both performed, since the read frees the slot in the same edge; count stays DEPTH; no error.
  - RD_PRIORITY=0, both asserted, count==0: write performed (count becomes 1); read illegal (underflow); no fall-through; dout holds.
- error<=1 on the edge after an illegal read or write attempt, otherwise error<=0. It is never sticky.
- An illegal operation changes no pointer, count or memory.
- ovf/udf set on an illegal write/read and stay set until clr_status=1 or reset. If clr_status and a new illegal event coincide, the set wins.
- count update: +1 (legal write only), -1 (legal read only), 0 otherwise. Flags are recomputed from the next count so they agree with count on the same cycle.
- Idle (wen=ren=0): no state change; error<=0.

Test Plan:
- Reset/idle, DATA_W=8, DEPTH=8: hold rst_n=0 for 2 edges with wen=ren=1, din=8'hAA -> dout=0, count=0, empty=1, almost_empty=1, error=0, ovf=udf=0.
- Fill and overflow: write 1..8 on 8 edges -> full=1, almost_full=1 from count 6, count=8. Write 9 -> error pulses 1 cycle, ovf=1, count=8. Drain 8 reads -> dout 1..8 in order, empty=1.
- Underflow: with FIFO empty, ren=1 for 1 edge -> error=1, udf=1, dout holds 8. Assert clr_status -> udf=0.
- Legacy priority (RD_PRIORITY=1): write 87; then ren=wen=1, din=85 -> dout=87, count=0, error=0. A following read -> error=1 (85 was dropped).
- Concurrent mode (RD_PRIORITY=0): fill with 10..17; ren=wen=1, din=99 -> dout=10, count=8, error=0. Drain -> 11..17 then 99. With empty: ren=wen=1, din=5 -> error=1, count=1. Next read -> dout=5.
- Wrap-around: 20 cycles of interleaved write/read with DEPTH=8 -> FIFO order preserved across pointer wrap; count never exceeds 8.
